shnorm: RTL and testbench
=========================

SHNORM -- requirements
Module: shnorm

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width; only 64 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_vld, input, 1, request valid.
REQ-005 SHALL have port in_rdy, output, 1, block can accept a request this cycle.
REQ-006 SHALL have port op, input, 2, 0=CLZ, 1=CTZ, 2=NORML (shift left by clz), 3=NORMR (shift right by ctz).
REQ-007 SHALL have port sz, input, 1, 1=64-bit operand, 0=32-bit operand.
REQ-008 SHALL have port val0, input, WIDTH, operand.
REQ-009 SHALL have port flush, input, 1, discard all in-flight requests.
REQ-010 SHALL have port out_vld, output, 1, result valid.
REQ-011 SHALL have port out_rdy, input, 1, consumer accepts the result.
REQ-012 SHALL have port valres, output, WIDTH, shifted result.
REQ-013 SHALL have port cnt, output, 7, bit count (0..64).
REQ-014 SHALL have port zero, output, 1, operand was zero.

Function
REQ-015 SHALL transfer a request when in_vld && in_rdy, and a result when out_vld && out_rdy.
REQ-016 SHALL be a 2-stage pipeline: S1 registers per-byte zero flags and the first/last non-zero byte index (3 bits) plus op, sz, operand; S2 registers the bit index within that byte, final cnt, valres, zero.
REQ-017 SHALL present the result 2 cycles after acceptance when out_rdy stays high, and sustain 1 request/cycle.
REQ-018 SHALL hold each stage when its downstream is full and not advancing; in_rdy = ~S1_vld | (S1 advances), S1 advances when ~S2_vld | out_rdy.
REQ-019 SHALL, for sz=0, ignore val0[63:32], compute over bits 31:0, and drive valres[63:32]=0.
REQ-020 SHALL for CLZ/NORML set cnt = number of zero bits above the highest set bit of the operand width.
REQ-021 SHALL for CTZ/NORMR set cnt = number of zero bits below the lowest set bit.
REQ-022 SHALL drive valres = operand << cnt (NORML), operand >> cnt logical (NORMR), 0 (CLZ/CTZ), truncated to operand width.
REQ-023 SHALL, for a zero operand, drive cnt = 32 (sz=0) or 64 (sz=1), valres=0, zero=1; zero=0 otherwise.
REQ-024 SHALL implement the shift as a byte-granular stage (S1 index) followed by a 0..7 bit stage (S2 index), no per-bit 64-way mux chain.
REQ-025 SHALL, on flush, clear S1_vld and S2_vld at the next edge; a request presented with flush is not accepted (in_rdy=0 while flush=1).
REQ-026 SHALL keep valres, cnt, zero stable while out_vld=1 and out_rdy=0.
REQ-027 SHALL treat out_rdy with out_vld=0 as no-op.

Reset
REQ-028 SHALL on rst clear S1_vld and S2_vld, driving out_vld=0, valres=0, cnt=0, zero=0, in_rdy=0 during the rst cycle and 1 the cycle after.
REQ-029 SHALL give rst priority over flush and any transfer; an in-flight request during rst is dropped with no output.

Verification
REQ-030 SHALL cover CLZ sz=1 val0=0x0000_00F0_0000_0000, out_rdy=1 -> 2 cycles later out_vld=1, cnt=24, valres=0, zero=0.
REQ-031 SHALL cover NORML sz=0 val0=0xFFFF_FFFF_0000_0100 -> cnt=23, valres=0x0000_0000_8000_0000.
REQ-032 SHALL cover NORMR sz=1 val0=0x8000_0000_0000_0000 -> cnt=63, valres=1; CTZ sz=1 val0=0 -> cnt=64, zero=1.
REQ-033 SHALL cover back-to-back 4 requests with out_rdy held 0 for 3 cycles -> in_rdy drops after 2 accepted, results emerge in order, unchanged while stalled.
REQ-034 SHALL cover flush with both stages full -> out_vld=0 next cycle, no stale result ever appears.
REQ-035 SHALL cover rst asserted mid-stream for 1 cycle -> all outputs 0, next accepted request yields correct result 2 cycles later.

Source files
------------

// File: rtl/shnorm.sv
// shnorm: two-stage count-leading/trailing-zeros and normalising shifter.
// Stage 1 finds the outermost non-zero bytes; stage 2 resolves the bit within that byte.
module shnorm #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [1:0]       op,
    input  logic             sz,
    input  logic [WIDTH-1:0] val0,
    input  logic             flush,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] valres,
    output logic [6:0]       cnt,
    output logic             zero
);
    function automatic logic [2:0] hi_idx(input logic [7:0] f);
        hi_idx = '0;
        for (int i = 0; i < 8; i++) if (f[i]) hi_idx = 3'(i);
    endfunction

    function automatic logic [2:0] lo_idx(input logic [7:0] f);
        lo_idx = '0;
        for (int i = 7; i >= 0; i--) if (f[i]) lo_idx = 3'(i);
    endfunction

    function automatic logic [2:0] lzc8(input logic [7:0] b);
        lzc8 = '0;
        for (int i = 0; i < 8; i++) if (b[i]) lzc8 = 3'(7 - i);
    endfunction

    function automatic logic [2:0] tzc8(input logic [7:0] b);
        tzc8 = '0;
        for (int i = 7; i >= 0; i--) if (b[i]) tzc8 = 3'(i);
    endfunction

    logic        s1_vld_q, s2_vld_q, s1_adv, s1_free, acc;
    logic [1:0]  op_q;
    logic        sz_q;
    logic [63:0] opd_d, opd_q;
    logic [7:0]  nz_d, nz_q;
    logic [2:0]  hi_d, hi_q, lo_d, lo_q;
    logic [63:0] valres_d, valres_q;
    logic [6:0]  cnt_d, cnt_q;
    logic        zero_d, zero_q;

    assign s1_adv  = ~s2_vld_q | out_rdy;
    assign s1_free = ~s1_vld_q | s1_adv;
    assign in_rdy  = s1_free & ~flush & ~rst;
    assign acc     = in_vld & in_rdy;

    always_comb begin
        opd_d = sz ? val0 : {32'b0, val0[31:0]};
        for (int i = 0; i < 8; i++) nz_d[i] = |opd_d[8*i +: 8];
        hi_d = hi_idx(nz_d);
        lo_d = lo_idx(nz_d);
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            op_q  <= op;
            sz_q  <= sz;
            opd_q <= opd_d;
            nz_q  <= nz_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    logic [7:0]  hb, lb;
    logic [2:0]  lz, tz, shl_b;
    logic [5:0]  clz64;
    logic [6:0]  cnt_l, cnt_r;
    logic [63:0] byte_l, bit_l, byte_r, bit_r, mask;

    // Byte-granular shift from the stage-1 index, then a 0..7 bit shift.
    always_comb begin
        hb       = opd_q[{hi_q, 3'b0} +: 8];
        lb       = opd_q[{lo_q, 3'b0} +: 8];
        lz       = lzc8(hb);
        tz       = tzc8(lb);
        clz64    = {3'd7 - hi_q, lz};
        cnt_l    = sz_q ? {1'b0, clz64} : {1'b0, clz64} - 7'd32;
        cnt_r    = {1'b0, lo_q, tz};
        shl_b    = (sz_q ? 3'd7 : 3'd3) - hi_q;
        byte_l   = opd_q << {shl_b, 3'b0};
        bit_l    = byte_l << lz;
        byte_r   = opd_q >> {lo_q, 3'b0};
        bit_r    = byte_r >> tz;
        mask     = sz_q ? '1 : {32'b0, 32'hFFFF_FFFF};
        zero_d   = ~|nz_q;
        cnt_d    = zero_d ? (sz_q ? 7'd64 : 7'd32) : op_q[0] ? cnt_r : cnt_l;
        valres_d = (zero_d | ~op_q[1]) ? '0 : (op_q[0] ? bit_r : bit_l) & mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            valres_q <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
        end else begin
            s1_vld_q <= flush ? 1'b0 : s1_free ? acc : s1_vld_q;
            s2_vld_q <= flush ? 1'b0 : s1_adv ? s1_vld_q : s2_vld_q;
            if (s1_adv & s1_vld_q) begin
                valres_q <= valres_d;
                cnt_q    <= cnt_d;
                zero_q   <= zero_d;
            end
        end
    end

    assign out_vld = s2_vld_q;
    assign valres  = valres_q;
    assign cnt     = cnt_q;
    assign zero    = zero_q;
endmodule

// File: tb/tb_shnorm.sv
// tb_shnorm: scoreboard bench; driver queues hand-computed results, monitor checks outputs.
module tb_shnorm;
    logic        clk = 0, rst = 1, in_vld = 0, sz = 0, flush = 0, out_rdy = 0;
    logic        in_rdy, out_vld, zero;
    logic [1:0]  op = 0;
    logic [63:0] val0 = 0, valres;
    logic [6:0]  cnt;

    shnorm #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .op(op), .sz(sz),
        .val0(val0), .flush(flush), .out_vld(out_vld), .out_rdy(out_rdy),
        .valres(valres), .cnt(cnt), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {logic [63:0] v; logic [6:0] c; logic z; int cyc; bit lat;} exp_t;
    exp_t q[$];
    exp_t e;
    int tests = 0, fails = 0, cyc = 0, acc_n = 0;
    logic        stl = 0, sz_s;
    logic [63:0] sv;
    logic [6:0]  sc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_vld) begin
            if (stl) begin
                chk("stall_valres", valres, sv);
                chk("stall_cnt", 64'(cnt), 64'(sc));
                chk("stall_zero", 64'(zero), 64'(sz_s));
            end
            if (out_rdy) begin
                stl = 0;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got valres %h cnt %0d with nothing outstanding", valres, cnt);
                end else begin
                    e = q.pop_front();
                    chk("valres", valres, e.v);
                    chk("cnt", 64'(cnt), 64'(e.c));
                    chk("zero", 64'(zero), 64'(e.z));
                    if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
                end
            end else begin
                stl = 1;
                sv = valres;
                sc = cnt;
                sz_s = zero;
            end
        end else stl = 0;
    end

    // Called at posedge+2; returns at posedge+2 after the request is taken.
    task automatic send(input logic [1:0] o, input logic s, input logic [63:0] v,
                        input logic [63:0] ev, input logic [6:0] ec, input logic ez, input bit lat);
        int n = 0;
        op = o; sz = s; val0 = v; in_vld = 1;
        @(negedge clk);
        while (!in_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_rdy 0 after %0d cycles, required 1", n);
        end else begin
            q.push_back('{v: ev, c: ec, z: ez, cyc: cyc, lat: lat});
            acc_n++;
        end
        @(posedge clk);
        #2 in_vld = 0;
    endtask

    task automatic drain;
        int n = 0;
        while (q.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        #2;
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_vld", 64'(out_vld), 0);
        chk("rst_valres", valres, 0);
        chk("rst_cnt", 64'(cnt), 0);
        chk("rst_zero", 64'(zero), 0);
        chk("rst_in_rdy", 64'(in_rdy), 0);
        @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("post_rst_in_rdy", 64'(in_rdy), 1);
        @(posedge clk);
        #2 out_rdy = 1;

        send(0, 1, 64'h0000_00F0_0000_0000, 64'h0, 24, 0, 1);
        send(2, 0, 64'hFFFF_FFFF_0000_0100, 64'h8000_0000, 23, 0, 1);
        send(3, 1, 64'h8000_0000_0000_0000, 64'h1, 63, 0, 1);
        send(1, 1, 64'h0, 64'h0, 64, 1, 1);
        send(0, 0, 64'hFFFF_FFFF_0000_0001, 64'h0, 31, 0, 1);
        send(1, 1, 64'h0000_0100_0000_0000, 64'h0, 40, 0, 1);
        send(3, 0, 64'hFFFF_0000_0000_0000, 64'h0, 32, 1, 1);
        send(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 0, 1);
        send(2, 1, 64'h1, 64'h8000_0000_0000_0000, 63, 0, 1);
        send(3, 0, 64'h1234_5678_0000_0F00, 64'hF, 8, 0, 1);
        send(2, 1, 64'h00F0_0000_0000_0000, 64'hF000_0000_0000_0000, 8, 0, 1);
        send(1, 0, 64'h0000_0001_0000_0000, 64'h0, 32, 1, 1);
        send(2, 0, 64'h0000_0000_0001_8000, 64'hC000_0000, 15, 0, 1);
        send(3, 1, 64'hA000_0000_0000_0000, 64'h5, 61, 0, 1);
        send(2, 1, 64'h0, 64'h0, 64, 1, 1);
        drain();

        out_rdy = 0;
        acc_n = 0;
        fork
            begin
                send(0, 0, 64'h0001_0000, 64'h0, 15, 0, 0);
                send(1, 0, 64'h0001_0000, 64'h0, 16, 0, 0);
                send(3, 1, 64'hF0, 64'hF, 4, 0, 0);
                send(2, 0, 64'hFFFF_FFFF_0000_FFFF, 64'hFFFF_0000, 16, 0, 0);
            end
            begin
                repeat (3) @(negedge clk);
                chk("stall_in_rdy", 64'(in_rdy), 0);
                chk("stall_accepted", 64'(acc_n), 2);
                @(posedge clk);
                #2 out_rdy = 1;
            end
        join
        drain();

        out_rdy = 0;
        send(0, 1, 64'h5, 64'h0, 61, 0, 0);
        send(1, 1, 64'h6, 64'h0, 1, 0, 0);
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        flush = 1; in_vld = 1; op = 0; sz = 1; val0 = 64'h1;
        @(negedge clk);
        chk("flush_in_rdy_full", 64'(in_rdy), 0);
        @(posedge clk);
        #2 q.delete();
        out_rdy = 1;
        @(negedge clk);
        chk("flush_out_vld", 64'(out_vld), 0);
        chk("flush_reqd_in_rdy", 64'(in_rdy), 0);
        @(posedge clk);
        #2 flush = 0; in_vld = 0;
        repeat (4) @(negedge clk);
        chk("flush_no_stale", 64'(out_vld), 0);
        @(posedge clk);
        #2;

        send(0, 1, 64'h100, 64'h0, 55, 0, 0);
        send(1, 1, 64'h100, 64'h0, 8, 0, 0);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_in_rdy", 64'(in_rdy), 0);
        @(posedge clk);
        #2 rst = 0;
        q.delete();
        @(negedge clk);
        chk("mid_rst_out_vld", 64'(out_vld), 0);
        chk("mid_rst_valres", valres, 0);
        chk("mid_rst_cnt", 64'(cnt), 0);
        chk("mid_rst_zero", 64'(zero), 0);
        chk("mid_rst_in_rdy_after", 64'(in_rdy), 1);
        @(posedge clk);
        #2;
        send(1, 0, 64'h8000_0000, 64'h0, 31, 0, 1);
        send(3, 0, 64'h8000_0000, 64'h1, 31, 0, 1);
        drain();
        chk("queue_empty", 64'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
